// File: rtl/kem_pkg.sv
// Shared KEM constants and FSM state encoding, used by the syndrome encoder
// and the bit-flipping decoder.
package kem_pkg;

    localparam int unsigned KEM_R     = 127;
    localparam int unsigned KEM_W     = 5;
    localparam int unsigned KEM_POS_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_CALC  = 2'd2,
        ST_DONE  = 2'd3
    } kem_state_t;

endpackage

// File: rtl/mod_r_add.sv
// (i + pos) mod R by a single conditional subtract; both operands are
// expected below R, so one subtraction is always enough.
module mod_r_add
    import kem_pkg::*;
#(
    parameter int unsigned R     = KEM_R,
    parameter int unsigned POS_W = KEM_POS_W,
    parameter int unsigned I_W   = 7
) (
    input  logic [I_W-1:0]   i,
    input  logic [POS_W-1:0] pos,
    output logic [POS_W-1:0] idx
);

    logic [POS_W:0] sum;
    logic [POS_W:0] wrapped;

    always_comb begin
        sum     = {1'b0, pos} + (POS_W+1)'(i);
        wrapped = sum - (POS_W+1)'(R);
        idx     = (sum >= (POS_W+1)'(R)) ? wrapped[POS_W-1:0] : sum[POS_W-1:0];
    end

endmodule

// File: rtl/syndrome_encoder.sv
// Sparse QC syndrome encoder: walks every (i,k) pair, one per cycle, and
// toggles s at (i + h_pos[k]) mod R for each set error bit.
module syndrome_encoder
    import kem_pkg::*;
#(
    parameter int unsigned R     = KEM_R,
    parameter int unsigned W     = KEM_W,
    parameter int unsigned POS_W = KEM_POS_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [R-1:0]         e0_in,
    input  logic [R-1:0]         e1_in,
    input  logic [W*POS_W-1:0]   h0_pos_flat,
    input  logic [W*POS_W-1:0]   h1_pos_flat,
    output logic [R-1:0]         s_out,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam int unsigned I_W = (R > 1) ? $clog2(R) : 1;
    localparam int unsigned K_W = (W > 1) ? $clog2(W) : 1;

    kem_state_t state, state_next;

    logic [R-1:0]       e0_r, e1_r;
    logic [W*POS_W-1:0] h0_r, h1_r;
    logic [I_W-1:0]     i_r;
    logic [K_W-1:0]     k_r;
    logic [R-1:0]       s_r;
    logic               err_r;
    logic               done_r;

    logic [POS_W-1:0]   pos0, pos1;
    logic [POS_W-1:0]   idx0, idx1;
    logic [R-1:0]       tog0, tog1;
    logic               bad_pos;
    logic               last_pair;

    always_comb begin
        pos0      = h0_r[k_r*POS_W +: POS_W];
        pos1      = h1_r[k_r*POS_W +: POS_W];
        last_pair = (i_r == I_W'(R-1)) && (k_r == K_W'(W-1));
        bad_pos   = 1'b0;
        for (int unsigned n = 0; n < W; n++) begin
            if (32'(h0_r[n*POS_W +: POS_W]) >= R) bad_pos = 1'b1;
            if (32'(h1_r[n*POS_W +: POS_W]) >= R) bad_pos = 1'b1;
        end
        // Coinciding toggles from e0 and e1 cancel in the XOR, leaving s[idx] unchanged.
        tog0 = R'(e0_r[i_r]) << idx0;
        tog1 = R'(e1_r[i_r]) << idx1;
    end

    mod_r_add #(.R(R), .POS_W(POS_W), .I_W(I_W)) u_add0 (
        .i   (i_r),
        .pos (pos0),
        .idx (idx0)
    );

    mod_r_add #(.R(R), .POS_W(POS_W), .I_W(I_W)) u_add1 (
        .i   (i_r),
        .pos (pos1),
        .idx (idx1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE:  if (start) state_next = ST_CHECK;
            ST_CHECK: state_next = bad_pos ? ST_DONE : ST_CALC;
            ST_CALC:  if (last_pair) state_next = ST_DONE;
            ST_DONE:  if (done_r && !start) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0_r   <= '0;
            e1_r   <= '0;
            h0_r   <= '0;
            h1_r   <= '0;
            i_r    <= '0;
            k_r    <= '0;
            s_r    <= '0;
            err_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        e0_r   <= e0_in;
                        e1_r   <= e1_in;
                        h0_r   <= h0_pos_flat;
                        h1_r   <= h1_pos_flat;
                        i_r    <= '0;
                        k_r    <= '0;
                        s_r    <= '0;
                        err_r  <= 1'b0;
                        done_r <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    if (bad_pos) err_r <= 1'b1;
                end
                ST_CALC: begin
                    s_r <= s_r ^ tog0 ^ tog1;
                    // Counters stop on the final pair instead of wrapping.
                    if (!last_pair) begin
                        if (k_r == K_W'(W-1)) begin
                            k_r <= '0;
                            i_r <= i_r + 1'b1;
                        end else begin
                            k_r <= k_r + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    // done rises first; the exit to IDLE is only taken once it is visible.
                    if (!done_r)     done_r <= 1'b1;
                    else if (!start) done_r <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign s_out = s_r;
    assign err   = err_r;
    assign done  = done_r;
    assign busy  = (state == ST_CHECK) || (state == ST_CALC);

endmodule

// File: tb/tb_syndrome_encoder.sv
// Self-checking bench for syndrome_encoder at R=5, W=3, POS_W=8.
module tb_syndrome_encoder;

    localparam int R = 5;
    localparam int W = 3;
    localparam int P = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [R-1:0]   e0_in, e1_in;
    logic [W*P-1:0] h0_pos_flat, h1_pos_flat;
    logic [R-1:0]   s_out;
    logic           busy, done, err;

    int tests  = 0;
    int failed = 0;

    typedef struct {
        logic [R-1:0]   e0;
        logic [R-1:0]   e1;
        logic [W*P-1:0] h0;
        logic [W*P-1:0] h1;
        logic [R-1:0]   s;
        logic           err;
        int             lat;
    } vec_t;

    typedef struct {
        logic [R-1:0] s;
        logic         err;
        int           lat;
    } exp_t;

    vec_t vecs[10];
    exp_t sb[$];

    syndrome_encoder #(.R(R), .W(W), .POS_W(P)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .e0_in       (e0_in),
        .e1_in       (e1_in),
        .h0_pos_flat (h0_pos_flat),
        .h1_pos_flat (h1_pos_flat),
        .s_out       (s_out),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    function automatic logic [W*P-1:0] pack3(input int a, input int b, input int c);
        logic [W*P-1:0] r;
        r = {8'(c), 8'(b), 8'(a)};
        return r;
    endfunction

    function automatic exp_t model(input logic [R-1:0] e0, input logic [R-1:0] e1,
                                   input logic [W*P-1:0] h0, input logic [W*P-1:0] h1);
        exp_t r;
        int p0, p1;
        r.s   = '0;
        r.err = 1'b0;
        r.lat = R*W + 2;
        for (int k = 0; k < W; k++)
            if (int'(h0[k*P +: P]) >= R || int'(h1[k*P +: P]) >= R) r.err = 1'b1;
        if (r.err) begin
            r.lat = 2;
            return r;
        end
        for (int i = 0; i < R; i++) begin
            for (int k = 0; k < W; k++) begin
                p0 = int'(h0[k*P +: P]);
                p1 = int'(h1[k*P +: P]);
                if (e0[i]) r.s[(i+p0)%R] = ~r.s[(i+p0)%R];
                if (e1[i]) r.s[(i+p1)%R] = ~r.s[(i+p1)%R];
            end
        end
        return r;
    endfunction

    task automatic check(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            failed++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit hold);
        exp_t e;
        exp_t x;
        int lat, busy_cnt, bad;
        @(negedge clk);
        e0_in = v.e0; e1_in = v.e1; h0_pos_flat = v.h0; h1_pos_flat = v.h1;
        start = 1'b1;
        x.s = v.s; x.err = v.err; x.lat = v.lat;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        // Inputs change after capture and must not influence the result.
        e0_in = ~v.e0; e1_in = ~v.e1;
        h0_pos_flat = W*P'($urandom); h1_pos_flat = W*P'($urandom);
        if (!hold) start = 1'b0;
        lat = 0; busy_cnt = 0;
        while (!done && lat < 200) begin
            if (busy) busy_cnt++;
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        e = sb.pop_front();
        check("latency", lat, e.lat);
        check("busy_cycles", busy_cnt, e.lat - 1);
        check("s_out", int'(s_out), int'(e.s));
        check("err", int'(err), int'(e.err));
        if (hold) begin
            bad = 0;
            repeat (5) begin
                @(posedge clk); @(negedge clk);
                if (!done || busy) bad++;
            end
            check("held_done", bad, 0);
            start = 1'b0;
            @(posedge clk); @(negedge clk);
            check("done_cleared", int'(done), 0);
            bad = 0;
            repeat (20) begin
                @(posedge clk); @(negedge clk);
                if (done || busy) bad++;
            end
            check("no_retrigger", bad, 0);
            check("s_held", int'(s_out), int'(e.s));
        end else begin
            @(posedge clk); @(negedge clk);
            check("done_cleared", int'(done), 0);
            check("s_held", int'(s_out), int'(e.s));
            check("err_held", int'(err), int'(e.err));
        end
    endtask

    initial begin
        exp_t m;
        rst = 1'b1; start = 1'b0;
        e0_in = '0; e1_in = '0; h0_pos_flat = '0; h1_pos_flat = '0;

        vecs[0] = '{5'b01100, 5'b00010, pack3(0,1,4), pack3(1,2,3), 5'b01110, 1'b0, 17};
        vecs[1] = '{5'b00000, 5'b00000, pack3(2,3,1), pack3(4,0,2), 5'b00000, 1'b0, 17};
        vecs[2] = '{5'b00001, 5'b00001, pack3(0,1,4), pack3(0,1,4), 5'b00000, 1'b0, 17};
        vecs[3] = '{5'b11111, 5'b10101, pack3(0,5,4), pack3(1,2,3), 5'b00000, 1'b1, 2};
        vecs[4] = '{5'b10010, 5'b01001, pack3(1,2,3), pack3(1,2,200), 5'b00000, 1'b1, 2};
        for (int n = 5; n < 10; n++) begin
            vecs[n].e0 = R'($urandom);
            vecs[n].e1 = R'($urandom);
            vecs[n].h0 = pack3($urandom_range(0,4), $urandom_range(0,4), $urandom_range(0,4));
            vecs[n].h1 = pack3($urandom_range(0,4), $urandom_range(0,4), $urandom_range(0,4));
            if (n == 9) vecs[n].h1 = pack3($urandom_range(0,4), $urandom_range(5,255), 0);
            m = model(vecs[n].e0, vecs[n].e1, vecs[n].h0, vecs[n].h1);
            vecs[n].s = m.s; vecs[n].err = m.err; vecs[n].lat = m.lat;
        end

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_s_out", int'(s_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_err", int'(err), 0);
        rst = 1'b0;

        for (int n = 0; n < 10; n++) run_vec(vecs[n], 1'b0);

        // Reset in the middle of CALC, then a fresh run must still be correct.
        @(negedge clk);
        e0_in = vecs[0].e0; e1_in = vecs[0].e1;
        h0_pos_flat = vecs[0].h0; h1_pos_flat = vecs[0].h1;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_s_out", int'(s_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_done", int'(done), 0);
        check("midrst_err", int'(err), 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(vecs[0], 1'b0);

        run_vec(vecs[0], 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end

endmodule
